// File: rtl/dsbpm_tbt_pkg.sv
// Shared types and defaults for the turn-by-turn I/Q summation path.
// Provides the state enum, default widths and the counter-width helper.
package dsbpm_tbt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int DEF_SITE_SAMPLES_PER_TURN = 100;
  localparam int DEF_PRODUCT_WIDTH         = 33;

  // Bits needed to hold 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tbt_iq_acc_lane.sv
// Single signed accumulator lane with load / add / hold.
// Ports: clk, rst, i_load (restart), i_en (sample valid),
//        i_data (signed product), o_acc (running sum).
module tbt_iq_acc_lane
  import dsbpm_tbt_pkg::*;
#(
  parameter int PRODUCT_WIDTH = DEF_PRODUCT_WIDTH,
  parameter int ACC_WIDTH     = 40
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_load,
  input  logic                        i_en,
  input  logic signed [PRODUCT_WIDTH-1:0] i_data,
  output logic signed [ACC_WIDTH-1:0] o_acc
);

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_ext;

  assign w_ext = {{(ACC_WIDTH-PRODUCT_WIDTH){i_data[PRODUCT_WIDTH-1]}},
                  i_data};

  // A load with no valid sample starts the turn at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_en ? w_ext : '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/tbt_iq_accumulator.sv
// Per-channel turn-by-turn I/Q summation; one sum per turnMarker.
// Ports: clk, rst, samplesPerTurn, turnMarker, productValid,
//        productI/Q in; sumValid, sumI/Q, sumCount out;
//        errClear in; errTurnLong/errTurnShort sticky out.
// Macro TBT_COUNT_CHECK_EN enables the sample-count checks.
module tbt_iq_accumulator
  import dsbpm_tbt_pkg::*;
#(
  parameter int PRODUCT_WIDTH = DEF_PRODUCT_WIDTH,
  parameter int SITE_SAMPLES_PER_TURN = DEF_SITE_SAMPLES_PER_TURN,
  parameter int COUNT_WIDTH = count_width(SITE_SAMPLES_PER_TURN),
  parameter int ACC_WIDTH = PRODUCT_WIDTH + COUNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [COUNT_WIDTH-1:0]          samplesPerTurn,
  input  logic                            turnMarker,
  input  logic                            productValid,
  input  logic signed [PRODUCT_WIDTH-1:0] productI,
  input  logic signed [PRODUCT_WIDTH-1:0] productQ,
  output logic                            sumValid,
  output logic signed [ACC_WIDTH-1:0]     sumI,
  output logic signed [ACC_WIDTH-1:0]     sumQ,
  output logic [COUNT_WIDTH-1:0]          sumCount,
  input  logic                            errClear,
  output logic                            errTurnLong,
  output logic                            errTurnShort
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                      r_state;
  logic [COUNT_WIDTH-1:0]      r_count;
  logic                        r_sumValid;
  logic signed [ACC_WIDTH-1:0] r_sumI;
  logic signed [ACC_WIDTH-1:0] r_sumQ;
  logic [COUNT_WIDTH-1:0]      r_sumCount;

  logic                        w_accum;
  logic                        w_en;
  logic signed [ACC_WIDTH-1:0] w_accI;
  logic signed [ACC_WIDTH-1:0] w_accQ;

  assign w_accum = (r_state == ACCUM);
  // The marker-cycle sample always opens the new turn.
  assign w_en = productValid & (w_accum | turnMarker);

  tbt_iq_acc_lane #(
    .PRODUCT_WIDTH(PRODUCT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_lane_i (
    .clk   (clk),
    .rst   (rst),
    .i_load(turnMarker),
    .i_en  (w_en),
    .i_data(productI),
    .o_acc (w_accI)
  );

  tbt_iq_acc_lane #(
    .PRODUCT_WIDTH(PRODUCT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_lane_q (
    .clk   (clk),
    .rst   (rst),
    .i_load(turnMarker),
    .i_en  (w_en),
    .i_data(productQ),
    .o_acc (w_accQ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_sumValid <= 1'b0;
      r_sumI     <= '0;
      r_sumQ     <= '0;
      r_sumCount <= '0;
    end else begin
      r_sumValid <= 1'b0;
      if (turnMarker) begin
        // First marker out of IDLE has no finished turn to emit.
        if (w_accum) begin
          r_sumValid <= 1'b1;
          r_sumI     <= w_accI;
          r_sumQ     <= w_accQ;
          r_sumCount <= r_count;
        end
        r_state <= ACCUM;
        r_count <= productValid ? COUNT_WIDTH'(1) : '0;
      end else if (w_accum && productValid && r_count != CNT_MAX) begin
        r_count <= r_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign sumValid = r_sumValid;
  assign sumI     = r_sumI;
  assign sumQ     = r_sumQ;
  assign sumCount = r_sumCount;

`ifdef TBT_COUNT_CHECK_EN
  logic [COUNT_WIDTH-1:0] r_spt;
  logic                   r_errLong;
  logic                   r_errShort;
  logic                   w_chk;
  logic                   w_longSet;
  logic                   w_shortSet;

  // A latched target of zero turns checking off.
  assign w_chk = w_accum & (r_spt != '0);
  assign w_longSet = w_chk & ~turnMarker & productValid &
                     (r_count == r_spt);
  assign w_shortSet = w_chk & turnMarker & (r_count < r_spt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spt      <= '0;
      r_errLong  <= 1'b0;
      r_errShort <= 1'b0;
    end else begin
      if (turnMarker) begin
        r_spt <= samplesPerTurn;
      end
      // A new error in the clear cycle wins over the clear.
      r_errLong  <= w_longSet  | (r_errLong  & ~errClear);
      r_errShort <= w_shortSet | (r_errShort & ~errClear);
    end
  end

  assign errTurnLong  = r_errLong;
  assign errTurnShort = r_errShort;
`else
  logic w_unused;
  assign w_unused     = &{1'b0, errClear, samplesPerTurn};
  assign errTurnLong  = 1'b0;
  assign errTurnShort = 1'b0;
`endif

endmodule

// File: tb/tb_tbt_iq_accumulator.sv
// Directed scoreboard bench for tbt_iq_accumulator.
// Expected turn sums are queued as markers are driven.
module tb_tbt_iq_accumulator;
  import dsbpm_tbt_pkg::*;

  localparam int PW = 33;
  localparam int CW = 7;
  localparam int AW = PW + CW;
`ifdef TBT_COUNT_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CW-1:0]        samplesPerTurn;
  logic                 turnMarker;
  logic                 productValid;
  logic signed [PW-1:0] productI;
  logic signed [PW-1:0] productQ;
  logic                 sumValid;
  logic signed [AW-1:0] sumI;
  logic signed [AW-1:0] sumQ;
  logic [CW-1:0]        sumCount;
  logic                 errClear;
  logic                 errTurnLong;
  logic                 errTurnShort;

  tbt_iq_accumulator dut (
    .clk           (clk),
    .rst           (rst),
    .samplesPerTurn(samplesPerTurn),
    .turnMarker    (turnMarker),
    .productValid  (productValid),
    .productI      (productI),
    .productQ      (productQ),
    .sumValid      (sumValid),
    .sumI          (sumI),
    .sumQ          (sumQ),
    .sumCount      (sumCount),
    .errClear      (errClear),
    .errTurnLong   (errTurnLong),
    .errTurnShort  (errTurnShort)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint i;
    longint q;
    longint n;
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  int     errors = 0;
  int     checks = 0;
  longint mI, mQ, mN;
  bit     active = 1'b0;

  task automatic check(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference turn model, then drive one clock of stimulus.
  task automatic cyc(input bit m, input bit v,
                     input longint i, input longint q);
    if (m) begin
      if (active) sb.push_back('{mI, mQ, mN});
      active = 1'b1;
      mI = v ? i : 0;
      mQ = v ? q : 0;
      mN = v ? 1 : 0;
    end else if (active && v) begin
      mI += i;
      mQ += q;
      if (mN < 127) mN++;
    end
    turnMarker   = m;
    productValid = v;
    productI     = i[PW-1:0];
    productQ     = q[PW-1:0];
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sumValid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_sumValid", {63'd0, sumValid}, 0);
      end else begin
        e = sb.pop_front();
        check("sumI", sumI, e.i);
        check("sumQ", sumQ, e.q);
        check("sumCount", {57'd0, sumCount}, e.n);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    samplesPerTurn = 7'd100;
    turnMarker     = 1'b0;
    productValid   = 1'b0;
    productI       = '0;
    productQ       = '0;
    errClear       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_sumValid", {63'd0, sumValid}, 0);
    check("rst_sumI", sumI, 0);
    check("rst_sumQ", sumQ, 0);
    check("rst_sumCount", {57'd0, sumCount}, 0);
    check("rst_errLong", {63'd0, errTurnLong}, 0);
    check("rst_errShort", {63'd0, errTurnShort}, 0);

    // IDLE ignores products.
    repeat (4) cyc(0, 1, 55, 66);

    // Turn of 100 x (1000,-500).
    cyc(1, 1, 1000, -500);
    repeat (99) cyc(0, 1, 1000, -500);

    // Short turn: 98 samples.
    cyc(1, 1, 5, -3);
    check("t1_errLong", {63'd0, errTurnLong}, 0);
    check("t1_errShort", {63'd0, errTurnShort}, 0);
    repeat (97) cyc(0, 1, 5, -3);
    cyc(1, 0, 0, 0);
    check("short_set", {63'd0, errTurnShort}, {63'd0, CHK});
    errClear = 1'b1;
    cyc(0, 0, 0, 0);
    errClear = 1'b0;
    check("short_clr", {63'd0, errTurnShort}, 0);

    // Long turn: 102 samples, flag on the 101st.
    repeat (100) cyc(0, 1, -7, 9);
    check("long_at100", {63'd0, errTurnLong}, 0);
    cyc(0, 1, -7, 9);
    check("long_at101", {63'd0, errTurnLong}, {63'd0, CHK});
    cyc(0, 1, -7, 9);

    // Full-scale turn.
    cyc(1, 1, -(64'sd1 <<< 32), (64'sd1 <<< 32) - 1);
    check("long_noshort", {63'd0, errTurnShort}, 0);
    errClear = 1'b1;
    cyc(0, 1, -(64'sd1 <<< 32), (64'sd1 <<< 32) - 1);
    errClear = 1'b0;
    check("long_clr", {63'd0, errTurnLong}, 0);
    repeat (98) cyc(0, 1, -(64'sd1 <<< 32), (64'sd1 <<< 32) - 1);
    cyc(1, 0, 0, 0);
    check("fs_sumI_direct", sumI, -64'sd429496729600);

    // Marker-cycle sample and back-to-back markers.
    repeat (3) cyc(0, 1, 11, -11);
    cyc(1, 1, 7, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // Reset mid-turn after 50 samples.
    repeat (50) cyc(0, 1, 100, 200);
    #2 rst = 1'b1;
    active = 1'b0;
    turnMarker   = 1'b0;
    productValid = 1'b0;
    #1;
    check("mid_rst_sumValid", {63'd0, sumValid}, 0);
    check("mid_rst_sumI", sumI, 0);
    check("mid_rst_sumQ", sumQ, 0);
    check("mid_rst_sumCount", {57'd0, sumCount}, 0);
    check("mid_rst_errShort", {63'd0, errTurnShort}, 0);
    check("mid_rst_errLong", {63'd0, errTurnLong}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Count checking disabled with samplesPerTurn = 0.
    samplesPerTurn = 7'd0;
    cyc(1, 1, 3, 4);
    repeat (2) cyc(0, 1, 3, 4);
    cyc(1, 0, 0, 0);
    check("spt0_errShort", {63'd0, errTurnShort}, 0);
    check("spt0_errLong", {63'd0, errTurnLong}, 0);
    repeat (2) cyc(0, 1, -2, -2);
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    check("hold_sumI", sumI, -4);
    check("hold_sumCount", {57'd0, sumCount}, 2);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tbt_iq_accumulator.md
Name: tbt_iq_accumulator

Overview:
- Turn-by-turn (TBT) I/Q summation stage directly downstream of the per-channel LO mixer.
- Accumulates signed mixer products over one machine turn and emits one I/Q sum per turn.
- Sums feed the magnitude/CIC chain and the TBT recorder.
- One instance per ADC channel, in the ADC clock domain.

Parameters:
- PRODUCT_WIDTH, 33, signed mixer product width (16-bit sample + 18-bit LO - 1).
- SITE_SAMPLES_PER_TURN, 100, maximum samples per turn.
- COUNT_WIDTH, 7, width of the sample counter and of the samplesPerTurn config; ceil(log2(SITE_SAMPLES_PER_TURN+1)).
- ACC_WIDTH, PRODUCT_WIDTH+COUNT_WIDTH, signed accumulator and output width.

Ports:
- clk  in  1  ADC-domain clock.
- rst  in  1  reset.
- samplesPerTurn  in  COUNT_WIDTH  expected samples per turn. Quasi-static; sampled at each turn start.
- turnMarker  in  1  single-cycle turn-start strobe, aligned with the first sample of a turn.
- productValid  in  1  product sample valid.
- productI  in  PRODUCT_WIDTH  signed in-phase product.
- productQ  in  PRODUCT_WIDTH  signed quadrature product.
- sumValid  out  1  single-cycle strobe; sums are valid.
- sumI  out  ACC_WIDTH  signed I sum of the completed turn.
- sumQ  out  ACC_WIDTH  signed Q sum of the completed turn.
- sumCount  out  COUNT_WIDTH  number of samples in the emitted sum.
- errClear  in  1  clears the sticky error flags.
- errTurnLong  out  1  sticky: sample count exceeded samplesPerTurn.
- errTurnShort  out  1  sticky: marker arrived before samplesPerTurn samples.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: every output is 0; the state machine goes to IDLE; accumulators, counter and latched samplesPerTurn are cleared. A reset asserted mid-turn discards the partial sum and emits no sumValid.
- IDLE: products are ignored. On turnMarker, go to ACCUM and start a turn.
- ACCUM: on each productValid, accI += productI and accQ += productQ, sign-extended to ACC_WIDTH, and count += 1.
- Turn start (marker cycle):
  - accumulators load the current product if productValid is high, otherwise 0;
  - count loads 1 or 0 on the same condition;
  - samplesPerTurn is latched.
  - A sample arriving in the marker cycle always belongs to the new turn.
- Turn end:
  - The end of a turn is the next turnMarker while in ACCUM.
  - One cycle after that marker: sumValid=1, and sumI/sumQ/sumCount hold the finished turn's totals. Latency is 1 cycle from marker to sumValid.
  - Outputs hold their values until the next sumValid.
  - The first marker after IDLE produces no sumValid.
- Back-to-back markers (consecutive cycles): each emits a sum. A turn with zero samples emits sumI=sumQ=0 and sumCount=0.
- Counter overflow:
  - Once count reaches samplesPerTurn, further productValid samples are still accumulated.
  - count saturates at 2^COUNT_WIDTH-1; accumulators do not wrap within that bound.
- Width rule: no rounding or truncation; full-precision two's-complement sums.
- samplesPerTurn=0 disables count checking. Error flags are never set.
- errClear: clears both sticky flags on the next cycle. If errClear and a new error occur in the same cycle, the set wins.

Optional Feature:
- TBT_COUNT_CHECK_EN defined:
  - errTurnLong sets when a productValid arrives with count already equal to the latched samplesPerTurn.
  - errTurnShort sets when a marker ends a turn with sumCount < samplesPerTurn.
- TBT_COUNT_CHECK_EN undefined: both error outputs are tied to 0, and errClear and the latched samplesPerTurn are unused.

Decomposition:
- Shared package dsbpm_tbt_pkg:
  - state enum (IDLE, ACCUM);
  - default widths SITE_SAMPLES_PER_TURN and PRODUCT_WIDTH;
  - a function computing COUNT_WIDTH.
- One natural sub-module: tbt_iq_acc_lane, a single signed accumulator with load/add/hold. It is instantiated twice, for I and Q. Control stays in the parent.

Test Plan:
1. Reset, then marker, then 100 valid samples of I=+1000, Q=-500, then marker. Required: one cycle after the second marker, sumValid=1, sumI=100000, sumQ=-50000, sumCount=100, no errors.
2. samplesPerTurn=100 with only 98 samples between markers. Required: sumCount=98 and errTurnShort=1. Then errClear → flag 0 next cycle. In the macro-off build, the flag stays 0.
3. 102 samples per turn. Required: errTurnLong sets on the 101st sample; sumCount=102.
4. Full-scale I=-(2^32) for 100 samples. Required: sumI=-429496729600, exact, no wrap.
5. productValid asserted in the marker cycle with I=7. Required: the previous sum excludes the 7 and the new turn starts at 7. Also, markers on consecutive cycles → two sumValid pulses, the second with sumCount=1.
6. rst pulsed mid-turn after 50 samples. Required: all outputs 0, no sumValid. The next marker emits nothing; the marker after that emits a correct sum.
